svm_request_dispatcher: RTL and testbench
=========================================

// Module: svm_request_dispatcher
// PURPOSE
// Initiator side of the svm_detection request/result interface. Accepts per-flow feature vectors from the flow
// extraction stage into a queue, issues them to svm_detection with the data_valid/ready handshake, and tags each
// result from new_result/class with the flow_id of the vector that produced it.
// Sits between flow feature extraction and the classification result sink.
// PARAMETERS
// PARAM_WIDTH    `SVM_PARAM_WIDTH   bits per feature
// PARAM_COUNT    `SVM_PARAM_COUNT   features per vector
// CLASS_WIDTH    `SVM_CLASS_WIDTH   class code width
// FLOW_ID_WIDTH  16                 flow identifier width
// IN_DEPTH       8                  input queue depth, power of 2, >=2
// MAX_INFLIGHT   4                  max issued-but-unanswered vectors, power of 2
// PORTS
// clk            in   1                        single clock, rising edge
// reset_n        in   1                        asynchronous, active-low reset
// in_valid       in   1                        feature vector offered
// in_ready       out  1                        queue not full; transfer when in_valid&in_ready
// in_x           in   PARAM_WIDTH*PARAM_COUNT  feature vector, feature i at [(i+1)*PW-1 : i*PW]
// in_flow_id     in   FLOW_ID_WIDTH            tag travelling with the vector
// svm_x          out  PARAM_WIDTH*PARAM_COUNT  to svm_detection.x
// svm_data_valid out  1                        to svm_detection.data_valid, 1-cycle pulse
// svm_ready      in   1                        from svm_detection.ready
// svm_new_result in   1                        from svm_detection.new_result, 1-cycle pulse
// svm_class      in   CLASS_WIDTH              from svm_detection.class, valid with new_result
// out_valid      out  1                        tagged result, 1-cycle pulse, no backpressure
// out_flow_id    out  FLOW_ID_WIDTH            flow_id of result
// out_class      out  CLASS_WIDTH              class of result
// inflight       out  log2(MAX_INFLIGHT)+1     outstanding request count
// protocol_error out  1                        sticky: new_result seen with no outstanding request
// BEHAVIOUR
// - Reset (async assert, sync release): svm_data_valid=0, svm_x=0, out_valid=0, out_flow_id=0, out_class=0,
//   inflight=0, protocol_error=0, both queues empty. Reset mid-operation discards queued and in-flight work;
//   svm_detection is reset by the same source (inverted at top level).
// - Input: in_ready = !in_queue_full. A vector written at edge k is first issuable at edge k+1.
// - Issue, evaluated each edge: issue = !in_queue_empty && svm_ready && !svm_data_valid
//   && inflight<MAX_INFLIGHT. On issue: svm_x<=head.x, svm_data_valid<=1, pop in_queue, push head.flow_id onto tag
//   queue. Otherwise svm_data_valid<=0. No back-to-back pulses (ready may fall one cycle late).
// - svm_x holds its value from the issue edge until the next issue edge.
// - Result: on svm_new_result at edge r: out_valid<=1, out_class<=svm_class, out_flow_id<=tag head, pop tag
//   queue; out_* register at r, valid in the following cycle (1-cycle latency). Results return in issue order.
// - new_result with tag queue empty: out_valid stays 0, protocol_error<=1 (sticky until reset), inflight holds 0.
// - Issue and result at the same edge: tag push and pop both happen, inflight unchanged.
// - inflight = tag queue occupancy; MAX_INFLIGHT reached blocks issue only, input still accepted until full.
// - Queue pointers wrap modulo depth; full/empty by extra pointer bit.
// STRUCTURE
// - Widths come from the shared `SVM_* macros in svm_parameters.v; add `SVM_FLOW_ID_WIDTH there.
// - One sub-module: sync_fifo (first-word fall-through, WIDTH/DEPTH params, full/empty/count), instantiated
//   twice: input queue (PARAM_WIDTH*PARAM_COUNT+FLOW_ID_WIDTH x IN_DEPTH), tag queue (FLOW_ID_WIDTH x MAX_INFLIGHT).
// - Issue logic and result register stay in this module; no FSM beyond the data_valid toggle.
// TESTING (bench with a behavioural svm_detection model, configurable latency L and ready-drop timing)
// 1 Single vector flow_id=0x0012, model L=5 returns class 3 -> one svm_data_valid pulse, then out_valid with
//   out_flow_id=0x0012, out_class=3; inflight 0->1->0; svm_x equals in_x.
// 2 Push 10 vectors with svm_ready=0 -> in_ready drops after 8 accepted; raise ready -> 8 issues, no adjacent
//   data_valid cycles, out_flow_id sequence matches push order.
// 3 Model never answers, ready=1 -> exactly MAX_INFLIGHT=4 issues, inflight=4, issue stalls; then answer one ->
//   exactly one more issue.
// 4 Result and issue on the same edge -> inflight unchanged, correct flow_id pairing for 1000 random vectors
//   against the svm_parameters.test.vectors/classes lists.
// 5 Spurious new_result with inflight=0 -> protocol_error=1 and stays set, out_valid=0.
// 6 reset_n low for 1 cycle with 3 in flight and 5 queued -> all outputs at reset values immediately, in_ready=1
//   after release, next pushed vector tagged correctly.

Source files
------------

// File: rtl/svm_request_dispatcher_pkg.sv
// Shared widths and sizing helpers for the svm_detection request dispatcher.
// Defaults mirror the svm_detection core widths; FLOW_ID width is owned here.
package svm_request_dispatcher_pkg;

    localparam int SVM_PARAM_WIDTH      = 8;
    localparam int SVM_PARAM_COUNT      = 4;
    localparam int SVM_CLASS_WIDTH      = 4;
    localparam int SVM_FLOW_ID_WIDTH    = 16;
    localparam int DEFAULT_IN_DEPTH     = 8;
    localparam int DEFAULT_MAX_INFLIGHT = 4;

    // Pointer width for a power-of-two queue: index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/svm_request_dispatcher_if.sv
// Bundle of the feature input, svm_detection and tagged result signals.
// slave is the dispatcher's view; master is the surrounding environment.
interface svm_request_dispatcher_if
    import svm_request_dispatcher_pkg::*;
#(
    parameter int PARAM_WIDTH   = SVM_PARAM_WIDTH,
    parameter int PARAM_COUNT   = SVM_PARAM_COUNT,
    parameter int CLASS_WIDTH   = SVM_CLASS_WIDTH,
    parameter int FLOW_ID_WIDTH = SVM_FLOW_ID_WIDTH,
    parameter int MAX_INFLIGHT  = DEFAULT_MAX_INFLIGHT
);
    localparam int XW = PARAM_WIDTH * PARAM_COUNT;
    localparam int IW = $clog2(MAX_INFLIGHT) + 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [XW-1:0]            in_x;
    logic [FLOW_ID_WIDTH-1:0] in_flow_id;

    logic [XW-1:0]            svm_x;
    logic                     svm_data_valid;
    logic                     svm_ready;
    logic                     svm_new_result;
    logic [CLASS_WIDTH-1:0]   svm_class;

    logic                     out_valid;
    logic [FLOW_ID_WIDTH-1:0] out_flow_id;
    logic [CLASS_WIDTH-1:0]   out_class;
    logic [IW-1:0]            inflight;
    logic                     protocol_error;

    modport slave (
        input  in_valid, in_x, in_flow_id,
        input  svm_ready, svm_new_result, svm_class,
        output in_ready,
        output svm_x, svm_data_valid,
        output out_valid, out_flow_id, out_class, inflight, protocol_error
    );

    modport master (
        output in_valid, in_x, in_flow_id,
        output svm_ready, svm_new_result, svm_class,
        input  in_ready,
        input  svm_x, svm_data_valid,
        input  out_valid, out_flow_id, out_class, inflight, protocol_error
    );

endinterface

// File: rtl/svm_request_dispatcher_sync_fifo.sv
// First-word fall-through synchronous FIFO; head is visible whenever not empty.
// DEPTH must be a power of two >= 2; full/empty come from the extra wrap bit.
module svm_request_dispatcher_sync_fifo
    import svm_request_dispatcher_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PTRW = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  wr_ptr_reg;
    logic [PTRW-1:0]  rd_ptr_reg;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign count   = wr_ptr_reg - rd_ptr_reg;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/svm_request_dispatcher.sv
// Queues flow feature vectors, issues them to svm_detection one pulse at a time,
// and pairs each returned class with the flow_id of the vector that produced it.
module svm_request_dispatcher
    import svm_request_dispatcher_pkg::*;
#(
    parameter int PARAM_WIDTH   = SVM_PARAM_WIDTH,
    parameter int PARAM_COUNT   = SVM_PARAM_COUNT,
    parameter int CLASS_WIDTH   = SVM_CLASS_WIDTH,
    parameter int FLOW_ID_WIDTH = SVM_FLOW_ID_WIDTH,
    parameter int IN_DEPTH      = DEFAULT_IN_DEPTH,
    parameter int MAX_INFLIGHT  = DEFAULT_MAX_INFLIGHT
) (
    input  logic                    clk,
    input  logic                    reset_n,
    svm_request_dispatcher_if.slave bus
);
    localparam int XW = PARAM_WIDTH * PARAM_COUNT;
    localparam int DW = XW + FLOW_ID_WIDTH;
    localparam int QW = ptr_width(IN_DEPTH);
    localparam int IW = ptr_width(MAX_INFLIGHT);

    logic                     in_full;
    logic                     in_empty;
    logic [DW-1:0]            in_head;
    logic [QW-1:0]            in_count;
    logic                     tag_full;
    logic                     tag_empty;
    logic [FLOW_ID_WIDTH-1:0] tag_head;
    logic [IW-1:0]            tag_count;
    logic                     issue;
    logic                     result_ok;
    logic                     unused_ok;

    logic [XW-1:0]            svm_x_reg;
    logic                     svm_data_valid_reg;
    logic                     out_valid_reg;
    logic [FLOW_ID_WIDTH-1:0] out_flow_id_reg;
    logic [CLASS_WIDTH-1:0]   out_class_reg;
    logic                     protocol_error_reg;

    // Blocking on our own last pulse covers a ready that falls one cycle late.
    assign issue     = !in_empty && bus.svm_ready && !svm_data_valid_reg &&
                       (tag_count < IW'(MAX_INFLIGHT));
    assign result_ok = bus.svm_new_result && !tag_empty;
    assign unused_ok = &{1'b0, in_count, tag_full};

    svm_request_dispatcher_sync_fifo #(
        .WIDTH (DW),
        .DEPTH (IN_DEPTH)
    ) u_in_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (bus.in_valid),
        .wr_data ({bus.in_x, bus.in_flow_id}),
        .rd_en   (issue),
        .rd_data (in_head),
        .full    (in_full),
        .empty   (in_empty),
        .count   (in_count)
    );

    // Tag queue occupancy is the outstanding request count.
    svm_request_dispatcher_sync_fifo #(
        .WIDTH (FLOW_ID_WIDTH),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (issue),
        .wr_data (in_head[FLOW_ID_WIDTH-1:0]),
        .rd_en   (result_ok),
        .rd_data (tag_head),
        .full    (tag_full),
        .empty   (tag_empty),
        .count   (tag_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            svm_x_reg          <= '0;
            svm_data_valid_reg <= 1'b0;
            out_valid_reg      <= 1'b0;
            out_flow_id_reg    <= '0;
            out_class_reg      <= '0;
            protocol_error_reg <= 1'b0;
        end else begin
            svm_data_valid_reg <= issue;
            if (issue) svm_x_reg <= in_head[DW-1:FLOW_ID_WIDTH];
            out_valid_reg <= result_ok;
            if (result_ok) begin
                out_flow_id_reg <= tag_head;
                out_class_reg   <= bus.svm_class;
            end
            if (bus.svm_new_result && tag_empty) protocol_error_reg <= 1'b1;
        end
    end

    assign bus.in_ready       = !in_full;
    assign bus.svm_x          = svm_x_reg;
    assign bus.svm_data_valid = svm_data_valid_reg;
    assign bus.out_valid      = out_valid_reg;
    assign bus.out_flow_id    = out_flow_id_reg;
    assign bus.out_class      = out_class_reg;
    assign bus.inflight       = tag_count;
    assign bus.protocol_error = protocol_error_reg;

endmodule

// File: tb/tb_svm_request_dispatcher.sv
// Bench for svm_request_dispatcher: behavioural svm_detection model, queue
// scoreboard fed at acceptance, and a cycle monitor holding a queue-level reference.
`timescale 1ns/1ps
module tb_svm_request_dispatcher;
    import svm_request_dispatcher_pkg::*;

    localparam int PW  = SVM_PARAM_WIDTH;
    localparam int PC  = SVM_PARAM_COUNT;
    localparam int CW  = SVM_CLASS_WIDTH;
    localparam int FW  = SVM_FLOW_ID_WIDTH;
    localparam int XW  = PW * PC;
    localparam int QD  = DEFAULT_IN_DEPTH;
    localparam int MI  = DEFAULT_MAX_INFLIGHT;

    typedef struct {
        logic [XW-1:0] x;
        logic [FW-1:0] fid;
        logic [CW-1:0] cls;
    } exp_t;

    typedef struct {
        int            due;
        logic [CW-1:0] cls;
    } pend_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    svm_request_dispatcher_if #(
        .PARAM_WIDTH(PW), .PARAM_COUNT(PC), .CLASS_WIDTH(CW),
        .FLOW_ID_WIDTH(FW), .MAX_INFLIGHT(MI)
    ) bus ();

    svm_request_dispatcher #(
        .PARAM_WIDTH(PW), .PARAM_COUNT(PC), .CLASS_WIDTH(CW),
        .FLOW_ID_WIDTH(FW), .IN_DEPTH(QD), .MAX_INFLIGHT(MI)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    exp_t iss_q[$];
    exp_t res_q[$];

    // model controls
    int lat = 5;
    bit lat_rand = 0;
    int ready_mode = 1;
    int budget = -1;
    bit spurious_req = 0;

    // monitor reference state
    int m_pend = 0;
    int m_inf = 0;
    bit m_err = 0;
    int issue_cnt = 0;
    int overlap_cnt = 0;

    function automatic logic [CW-1:0] class_of(input logic [XW-1:0] x);
        int s = 0;
        for (int i = 0; i < PC; i++) s += int'(x[i*PW +: PW]);
        return CW'(s);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_svm_data_valid"}, bus.svm_data_valid, 0);
        chk({tag, "_svm_x"}, bus.svm_x, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_flow_id"}, bus.out_flow_id, 0);
        chk({tag, "_out_class"}, bus.out_class, 0);
        chk({tag, "_inflight"}, bus.inflight, 0);
        chk({tag, "_protocol_error"}, bus.protocol_error, 0);
    endtask

    // Caller must be at posedge+1; returns at posedge+1.
    task automatic push_vec(input logic [XW-1:0] x, input logic [FW-1:0] f);
        exp_t e;
        bit acc = 0;
        bus.in_valid = 1'b1;
        bus.in_x = x;
        bus.in_flow_id = f;
        for (int i = 0; i < 500 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!acc) fail_now("push_timeout");
        else begin
            e.x = x;
            e.fid = f;
            e.cls = class_of(x);
            iss_q.push_back(e);
        end
    endtask

    function automatic logic [XW-1:0] rand_x();
        logic [XW-1:0] v;
        for (int i = 0; i < PC; i++) v[i*PW +: PW] = PW'($urandom);
        return v;
    endfunction

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = (m_inf == 0 && m_pend == 0 && iss_q.size() == 0 && res_q.size() == 0);
        end
        if (!done) fail_now({name, "_drain_timeout"});
        align();
    endtask

    task automatic do_reset();
        align();
        #1;
        reset_n = 1'b0;
        bus.in_valid = 1'b0;
        iss_q.delete();
        res_q.delete();
        #1;
        check_reset_values("reset_immediate");
        chk("reset_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        align();
    endtask

    // behavioural svm_detection
    initial begin
        pend_t mq[$];
        pend_t p;
        int cyc = 0;
        int last_due = 0;
        bus.svm_new_result = 1'b0;
        bus.svm_class = '0;
        bus.svm_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!reset_n) begin
                mq.delete();
                last_due = 0;
                bus.svm_new_result = 1'b0;
                bus.svm_ready = 1'b0;
                continue;
            end
            if (bus.svm_data_valid) begin
                p.due = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat);
                if (p.due <= last_due) p.due = last_due + 1;
                p.cls = class_of(bus.svm_x);
                last_due = p.due;
                mq.push_back(p);
            end
            bus.svm_new_result = 1'b0;
            if (spurious_req) begin
                bus.svm_new_result = 1'b1;
                bus.svm_class = CW'($urandom);
                spurious_req = 0;
            end else if (mq.size() > 0 && mq[0].due <= cyc && budget != 0) begin
                p = mq.pop_front();
                bus.svm_new_result = 1'b1;
                bus.svm_class = p.cls;
                if (budget > 0) budget--;
            end
            case (ready_mode)
                0: bus.svm_ready = 1'b0;
                1: bus.svm_ready = 1'b1;
                default: bus.svm_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // monitor: queue-level reference of issue, occupancy and result pairing
    initial begin
        bit last_acc = 0, last_ready = 0, last_nr = 0, prev_dv = 0;
        bit should, pop;
        int pre;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_pend = 0; m_inf = 0; m_err = 0;
                last_acc = 0; last_ready = 0; last_nr = 0; prev_dv = 0;
                check_reset_values("in_reset");
                continue;
            end
            pre = m_inf;
            pop = last_nr && (pre > 0);
            if (last_nr && pre == 0) m_err = 1;
            should = (m_pend > 0) && last_ready && !prev_dv && (pre < MI);
            if (should && pop) overlap_cnt++;
            chk("issue", bus.svm_data_valid, should);
            if (bus.svm_data_valid) begin
                issue_cnt++;
                if (iss_q.size() == 0) fail_now("issue_without_vector");
                else begin
                    e = iss_q.pop_front();
                    chk("svm_x", bus.svm_x, e.x);
                    res_q.push_back(e);
                end
            end
            m_pend = m_pend - int'(should) + int'(last_acc);
            m_inf = pre + int'(should) - int'(pop);
            chk("out_valid", bus.out_valid, pop);
            if (bus.out_valid) begin
                if (res_q.size() == 0) fail_now("result_without_issue");
                else begin
                    e = res_q.pop_front();
                    $display("result flow_id=0x%04h class=%0d", bus.out_flow_id, bus.out_class);
                    chk("out_flow_id", bus.out_flow_id, e.fid);
                    chk("out_class", bus.out_class, e.cls);
                end
            end
            chk("inflight", bus.inflight, m_inf);
            chk("in_ready", bus.in_ready, m_pend < QD);
            chk("protocol_error", bus.protocol_error, m_err);
            prev_dv = should;
            last_acc = bus.in_valid && (m_pend < QD);
            last_ready = bus.svm_ready;
            last_nr = bus.svm_new_result;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [XW-1:0] x1;
        bus.in_valid = 1'b0;
        bus.in_x = '0;
        bus.in_flow_id = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        do_reset();

        // 1: single vector, latency 5, features 1 and 2 give class 3
        ready_mode = 1; lat = 5;
        x1 = '0;
        x1[PW-1:0] = PW'(1);
        x1[2*PW-1:PW] = PW'(2);
        push_vec(x1, 16'h0012);
        wait_drain("t1");

        // 2: fill queue with ready low, ninth vector refused, then drain in order
        ready_mode = 0;
        base = issue_cnt;
        for (int i = 0; i < 8; i++) push_vec(rand_x(), FW'(16'h0200 + i));
        bus.in_valid = 1'b1;
        bus.in_x = rand_x();
        bus.in_flow_id = 16'h0208;
        repeat (3) begin
            @(negedge clk);
            chk("t2_full_in_ready", bus.in_ready, 0);
        end
        align();
        bus.in_valid = 1'b0;
        ready_mode = 1;
        push_vec(rand_x(), 16'h0208);
        push_vec(rand_x(), 16'h0209);
        wait_drain("t2");
        chk("t2_issue_count", issue_cnt - base, 10);

        // 3: no answers -> exactly MAX_INFLIGHT issues, one answer frees one slot
        budget = 0;
        base = issue_cnt;
        for (int i = 0; i < 6; i++) push_vec(rand_x(), FW'(16'h0300 + i));
        repeat (30) @(negedge clk);
        chk("t3_issue_count", issue_cnt - base, MI);
        chk("t3_inflight", bus.inflight, MI);
        budget = 1;
        repeat (20) @(negedge clk);
        chk("t3_issue_after_one", issue_cnt - base, MI + 1);
        chk("t3_inflight_after_one", bus.inflight, MI);
        budget = -1;
        wait_drain("t3");

        // 4: random traffic with overlapping issue and result edges
        ready_mode = 2; lat_rand = 1;
        overlap_cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            push_vec(rand_x(), FW'($urandom));
            if ($urandom_range(0, 1) == 1) align();
        end
        wait_drain("t4");
        chk("t4_overlap_seen", overlap_cnt > 0, 1);
        lat_rand = 0; lat = 2; ready_mode = 1;

        // 5: spurious result while idle
        spurious_req = 1;
        repeat (10) @(negedge clk);
        chk("t5_protocol_error", bus.protocol_error, 1);
        align();
        push_vec(rand_x(), 16'h0500);
        wait_drain("t5");
        chk("t5_protocol_error_sticky", bus.protocol_error, 1);

        // 6: reset with 3 in flight and 5 queued
        budget = 0;
        for (int i = 0; i < 3; i++) push_vec(rand_x(), FW'(16'h0600 + i));
        repeat (10) @(negedge clk);
        ready_mode = 0;
        align();
        for (int i = 0; i < 5; i++) push_vec(rand_x(), FW'(16'h0610 + i));
        @(negedge clk);
        chk("t6_inflight_before_reset", bus.inflight, 3);
        do_reset();
        budget = -1; ready_mode = 1;
        @(negedge clk);
        chk("t6_in_ready_after", bus.in_ready, 1);
        align();
        push_vec(rand_x(), 16'hBEEF);
        wait_drain("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
